// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator: waveform mode codes and
// the amplitude gain width.
package dds_pkg;

  localparam logic [1:0] MODE_SINE   = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_SAW    = 2'd2;
  localparam logic [1:0] MODE_TRI    = 2'd3;

  localparam int AMP_W = 8;

endpackage

// File: rtl/dds_tick_div.sv
// Sample-rate divider: one-cycle tick every DIV clocks while enabled.
// While disabled, the count is held at zero.
module dds_tick_div
  import dds_pkg::*;
#(
  parameter int DIV = 5000
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count and tick decode
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dds_wavegen.sv
// DDS waveform source: phase accumulator, external sine ROM addressing,
// sine/square/saw/triangle selection and 8-bit amplitude scaling.
module dds_wavegen
  import dds_pkg::*;
#(
  parameter int TICK_DIV = 5000,
  parameter int ACC_W    = 24,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 10
) (
  input  logic              CLOCK_50,
  input  logic              RST_N,
  input  logic              enable,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic [ADDR_W-1:0] phase_offset,
  input  logic [1:0]        mode,
  input  logic [AMP_W-1:0]  amplitude,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid
);

  localparam int PH_W   = DATA_W + 1;
  localparam int PROD_W = DATA_W + AMP_W;

  logic                tick_s;
  logic [ACC_W-1:0]    acc_sum_s;
  logic [ACC_W+PH_W-1:0] ph_wide_s;
  logic [DATA_W-1:0]   wave_sel_s;
  logic [PROD_W-1:0]   prod_s;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [PH_W-1:0]     ph1_q, ph1_d;
  logic [PH_W-1:0]     ph2_q, ph2_d;
  logic [DATA_W-1:0]   wave_q, wave_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                v1_q, v1_d;
  logic                v2_q, v2_d;
  logic                v3_q, v3_d;
  logic                valid_q, valid_d;

  dds_tick_div #(
    .DIV (TICK_DIV)
  ) u_tick_div (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .enable   (enable),
    .tick     (tick_s)
  );

  // Zero-padding on the right keeps the top PH_W phase bits well defined
  // even when the accumulator is narrower than the phase word.
  assign acc_sum_s = acc_q + freq_word;
  assign ph_wide_s = {acc_sum_s, {PH_W{1'b0}}};

  // waveform shape from the delayed phase (or ROM for sine)
  always_comb begin
    wave_sel_s = rom_data;
    case (mode)
      MODE_SINE:   wave_sel_s = rom_data;
      MODE_SQUARE: wave_sel_s = ph2_q[DATA_W] ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      MODE_SAW:    wave_sel_s = ph2_q[DATA_W:1];
      MODE_TRI:    wave_sel_s = ph2_q[DATA_W] ? ~ph2_q[DATA_W-1:0] : ph2_q[DATA_W-1:0];
      default:     wave_sel_s = rom_data;
    endcase
  end

  assign prod_s = {{AMP_W{1'b0}}, wave_q} * {{DATA_W{1'b0}}, amplitude};

  // pipeline next-state: stage 0 on tick, stages 1-3 follow the valid chain
  always_comb begin
    acc_d      = acc_q;
    rom_addr_d = rom_addr_q;
    ph1_d      = ph1_q;
    wave_d     = wave_q;
    sample_d   = sample_q;
    if (tick_s) begin
      acc_d      = acc_sum_s;
      rom_addr_d = acc_sum_s[ACC_W-1 -: ADDR_W] + phase_offset;
      ph1_d      = ph_wide_s[ACC_W+PH_W-1 -: PH_W];
    end else begin
      acc_d      = acc_q;
    end
    ph2_d = ph1_q;
    v1_d  = tick_s;
    v2_d  = v1_q;
    v3_d  = v2_q;
    if (v2_q) begin
      wave_d = wave_sel_s;
    end else begin
      wave_d = wave_q;
    end
    if (v3_q) begin
      sample_d = prod_s[PROD_W-1 -: DATA_W];
    end else begin
      sample_d = sample_q;
    end
    valid_d = v3_q;
  end

  // state registers with synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      acc_q      <= '0;
      rom_addr_q <= '0;
      ph1_q      <= '0;
      ph2_q      <= '0;
      wave_q     <= '0;
      sample_q   <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      rom_addr_q <= rom_addr_d;
      ph1_q      <= ph1_d;
      ph2_q      <= ph2_d;
      wave_q     <= wave_d;
      sample_q   <= sample_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;

endmodule
